// File: rtl/gpio_bank_pkg.sv
// Shared constants, register offsets and interrupt FSM encoding for gpio_bank.
package gpio_bank_pkg;

  localparam int unsigned MAX_CH = 8;

  typedef enum logic [0:0] {
    StIdle,
    StRaised
  } irq_state_e;

  // Register window layout as a function of channel count.
  function automatic logic [7:0] IN_OFS(input int unsigned n_ch);
    logic unused_n;
    unused_n = ^n_ch;
    return 8'd0;
  endfunction

  function automatic logic [7:0] OUT_OFS(input int unsigned n_ch);
    return 8'(n_ch);
  endfunction

  function automatic logic [7:0] STATUS_OFS(input int unsigned n_ch);
    return 8'(2 * n_ch);
  endfunction

  function automatic logic [7:0] MASK_OFS(input int unsigned n_ch);
    return 8'(2 * n_ch + 1);
  endfunction

endpackage

// File: rtl/gpio_in_chan.sv
// One 8-bit input channel: synchroniser, optional debounce (GPIO_DEBOUNCE_EN),
// reference register and change flag.
module gpio_in_chan #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       primed_i,
  input  logic [7:0] pin_i,
  output logic [7:0] value_o,
  output logic       change_o
);

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] sync;
  logic [7:0] ref_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  logic [7:0]  deb_q, deb_d;
  logic [7:0]  prev_q;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (!primed_i) begin
      // Follow the synchroniser directly until priming completes.
      deb_d = sync;
    end else if ((sync == prev_q) && (sync != deb_q)) begin
      if (cnt_q >= DEBOUNCE_CYCLES - 16'd1) begin
        deb_d = sync;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_q  <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      deb_q  <= deb_d;
      prev_q <= sync;
      cnt_q  <= cnt_d;
    end
  end

  assign value_o = deb_q;
`else
  logic unused_deb;
  assign unused_deb = ^DEBOUNCE_CYCLES;
  assign value_o    = sync;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_q <= '0;
    end else begin
      ref_q <= value_o;
    end
  end

  assign change_o = primed_i && (value_o != ref_q);

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: N_CH input/output byte channels, change detection and
// a maskable RAISE/ACK interrupt. Optional input debounce via GPIO_DEBOUNCE_EN.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR       = 8'hB0,
  parameter int unsigned N_CH            = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic              CLK,
  input  logic              RESET,
  inout  wire  [7:0]        BUS_DATA,
  input  logic [7:0]        BUS_ADDR,
  input  logic              BUS_WE,
  input  logic [8*N_CH-1:0] GPIO_IN,
  output logic [8*N_CH-1:0] GPIO_OUT,
  output logic              BUS_INTERRUPT_RAISE,
  input  logic              BUS_INTERRUPT_ACK
);

  localparam logic [7:0] InOfs     = IN_OFS(N_CH);
  localparam logic [7:0] OutOfs    = OUT_OFS(N_CH);
  localparam logic [7:0] StatusOfs = STATUS_OFS(N_CH);
  localparam logic [7:0] MaskOfs   = MASK_OFS(N_CH);

  // Change detection stays disarmed until the input pipeline has filled with
  // real pin values, so held inputs at reset release never raise a change.
`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned PrimeCycles = SYNC_STAGES + 2;
`else
  localparam int unsigned PrimeCycles = SYNC_STAGES + 1;
`endif

  logic [7:0]      ofs;
  logic            in_win, wr_en, rd_en;
  logic [2:0]      prime_cnt_q;
  logic            primed;
  logic [7:0]      in_val [N_CH];
  logic [N_CH-1:0] change;
  logic [7:0]      out_q [N_CH];
  logic [7:0]      out_d [N_CH];
  logic [N_CH-1:0] status_q, status_d, status_clr;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [N_CH-1:0] pending, ack_clr;
  logic [7:0]      status_rd, mask_rd, rd_mux;
  logic [7:0]      rdata_q, rdata_d;
  logic            drive_q;
  irq_state_e      state_q, state_d;

  assign ofs    = BUS_ADDR - BASE_ADDR;
  assign in_win = (BUS_ADDR >= BASE_ADDR) && (ofs <= MaskOfs);
  assign wr_en  = in_win && BUS_WE;
  assign rd_en  = in_win && !BUS_WE;

  assign primed = (prime_cnt_q == 3'(PrimeCycles));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      prime_cnt_q <= '0;
    end else if (!primed) begin
      prime_cnt_q <= prime_cnt_q + 3'd1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    gpio_in_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i    (CLK),
      .rst_ni   (RESET),
      .primed_i (primed),
      .pin_i    (GPIO_IN[8*k +: 8]),
      .value_o  (in_val[k]),
      .change_o (change[k])
    );

    assign GPIO_OUT[8*k +: 8] = out_q[k];
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      out_d[k] = out_q[k];
      if (wr_en && (ofs == OutOfs + 8'(k))) begin
        out_d[k] = BUS_DATA;
      end
    end
  end

  assign pending = status_q & mask_q;

  always_comb begin
    state_d = state_q;
    ack_clr = '0;
    unique case (state_q)
      StIdle: begin
        if (|pending) begin
          state_d = StRaised;
        end
      end
      StRaised: begin
        if (BUS_INTERRUPT_ACK) begin
          state_d = StIdle;
          ack_clr = pending;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign BUS_INTERRUPT_RAISE = (state_q == StRaised);

  // New changes are OR-ed in after clearing so a same-edge set wins.
  always_comb begin
    status_clr = ack_clr;
    if (wr_en && (ofs == StatusOfs)) begin
      status_clr = status_clr | BUS_DATA[N_CH-1:0];
    end
    status_d = (status_q & ~status_clr) | change;
    mask_d   = (wr_en && (ofs == MaskOfs)) ? BUS_DATA[N_CH-1:0] : mask_q;
  end

  always_comb begin
    status_rd = '0;
    status_rd[N_CH-1:0] = status_q;
    mask_rd = '0;
    mask_rd[N_CH-1:0] = mask_q;
    rd_mux = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ofs == InOfs + 8'(k)) begin
        rd_mux = in_val[k];
      end
      if (ofs == OutOfs + 8'(k)) begin
        rd_mux = out_q[k];
      end
    end
    if (ofs == StatusOfs) begin
      rd_mux = status_rd;
    end
    if (ofs == MaskOfs) begin
      rd_mux = mask_rd;
    end
    rdata_d = rd_en ? rd_mux : rdata_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int k = 0; k < N_CH; k++) begin
        out_q[k] <= '0;
      end
      status_q <= '0;
      mask_q   <= '0;
      state_q  <= StIdle;
      rdata_q  <= '0;
      drive_q  <= 1'b0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        out_q[k] <= out_d[k];
      end
      status_q <= status_d;
      mask_q   <= mask_d;
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      drive_q  <= rd_en;
    end
  end

  assign BUS_DATA = drive_q ? rdata_q : 8'hzz;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank (N_CH=2, SYNC_STAGES=2, BASE_ADDR=8'hB0).
module tb_gpio_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  bus_addr = 8'h00;
  logic        bus_we = 1'b0;
  logic [7:0]  tb_data = 8'h00;
  logic        tb_drv = 1'b0;
  logic [15:0] gpio_in = 16'hA55A;
  logic [15:0] gpio_out;
  logic        raise;
  logic        ack = 1'b0;
  wire  [7:0]  bus;

  int n_vec  = 0;
  int n_fail = 0;

  assign bus = tb_drv ? tb_data : 8'hzz;

  always #5 clk = ~clk;

  gpio_bank #(
    .BASE_ADDR       (8'hB0),
    .N_CH            (2),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16'd50000)
  ) dut (
    .CLK                 (clk),
    .RESET               (rst_n),
    .BUS_DATA            (bus),
    .BUS_ADDR            (bus_addr),
    .BUS_WE              (bus_we),
    .GPIO_IN             (gpio_in),
    .GPIO_OUT            (gpio_out),
    .BUS_INTERRUPT_RAISE (raise),
    .BUS_INTERRUPT_ACK   (ack)
  );

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        rd_chk;
    logic [7:0]  exp_rd;
    logic        z_chk;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Undriven bus may resolve to z or to zero depending on the simulator.
  function automatic logic bus_idle();
    return (bus === 8'hzz) || (bus === 8'h00);
  endfunction

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus_addr = a;
    bus_we   = 1'b1;
    tb_data  = d;
    tb_drv   = 1'b1;
    tick();
    bus_we   = 1'b0;
    tb_drv   = 1'b0;
    bus_addr = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus_addr = a;
    tick();
    d = bus;
    bus_addr = 8'h00;
    tick();
  endtask

  task automatic wait_raise(input string name);
    for (int i = 0; i < 10 && !raise; i++) tick();
    check(name, {15'd0, raise}, 16'd1);
  endtask

  initial begin
    logic [7:0] d;
    logic       seen;

    //            we    addr   wdata  rd    exp    z     out
    vecs[0]  = '{1'b0, 8'hB0, 8'h00, 1'b1, 8'h5A, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 8'hB1, 8'h00, 1'b1, 8'hA5, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 8'hB2, 8'h3C, 1'b0, 8'h00, 1'b0, 16'h003C};
    vecs[3]  = '{1'b0, 8'hB2, 8'h00, 1'b1, 8'h3C, 1'b0, 16'h003C};
    vecs[4]  = '{1'b1, 8'hB3, 8'hC3, 1'b0, 8'h00, 1'b0, 16'hC33C};
    vecs[5]  = '{1'b0, 8'hB3, 8'h00, 1'b1, 8'hC3, 1'b0, 16'hC33C};
    vecs[6]  = '{1'b1, 8'hB0, 8'hFF, 1'b0, 8'h00, 1'b0, 16'hC33C};
    vecs[7]  = '{1'b0, 8'hB0, 8'h00, 1'b1, 8'h5A, 1'b0, 16'hC33C};
    vecs[8]  = '{1'b0, 8'hB4, 8'h00, 1'b1, 8'h00, 1'b0, 16'hC33C};
    vecs[9]  = '{1'b1, 8'hB5, 8'hFF, 1'b0, 8'h00, 1'b0, 16'hC33C};
    vecs[10] = '{1'b0, 8'hB5, 8'h00, 1'b1, 8'h03, 1'b0, 16'hC33C};
    vecs[11] = '{1'b1, 8'hB5, 8'h00, 1'b0, 8'h00, 1'b0, 16'hC33C};
    vecs[12] = '{1'b0, 8'hB5, 8'h00, 1'b1, 8'h00, 1'b0, 16'hC33C};
    vecs[13] = '{1'b1, 8'hB6, 8'h77, 1'b0, 8'h00, 1'b0, 16'hC33C};
    vecs[14] = '{1'b0, 8'hB6, 8'h00, 1'b0, 8'h00, 1'b1, 16'hC33C};
    vecs[15] = '{1'b1, 8'hAF, 8'h55, 1'b0, 8'h00, 1'b0, 16'hC33C};
    vecs[16] = '{1'b0, 8'hB2, 8'h00, 1'b1, 8'h3C, 1'b0, 16'hC33C};

    // Reset with inputs held; nothing may flag a change after release.
    repeat (3) tick();
    check("rst_out", gpio_out, 16'h0000);
    check("rst_raise", {15'd0, raise}, 16'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | raise;
    end
    check("prime_raise", {15'd0, seen}, 16'd0);
    rd(8'hB4, d);
    check("prime_status", {8'h00, d}, 16'h0000);

    foreach (vecs[i]) begin
      bus_addr = vecs[i].addr;
      bus_we   = vecs[i].we;
      tb_data  = vecs[i].wdata;
      tb_drv   = vecs[i].we;
      tick();
      bus_we   = 1'b0;
      tb_drv   = 1'b0;
      bus_addr = 8'h00;
      check($sformatf("v%0d_out", i), gpio_out, vecs[i].exp_out);
      if (vecs[i].rd_chk) check($sformatf("v%0d_rd", i), {8'h00, bus}, {8'h00, vecs[i].exp_rd});
      if (vecs[i].z_chk) check($sformatf("v%0d_hiz", i), {15'd0, bus_idle()}, 16'd1);
      if (!vecs[i].we) begin
        tick();
        check($sformatf("v%0d_release", i), {15'd0, bus_idle()}, 16'd1);
      end
    end

    // IRQ handshake on channel 1, with pin-to-STATUS latency.
    wr(8'hB5, 8'h02);
    gpio_in[8] = 1'b0;
    tick();
    tick();
    bus_addr = 8'hB4;
    tick();
    check("hs_status_early", {8'h00, bus}, 16'h0000);
    check("hs_raise_early", {15'd0, raise}, 16'd0);
    tick();
    check("hs_status", {8'h00, bus}, 16'h0002);
    check("hs_raise", {15'd0, raise}, 16'd1);
    bus_addr = 8'h00;
    tick();
    rd(8'hB1, d);
    check("hs_in1", {8'h00, d}, 16'h00A4);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("hs_ack_drop", {15'd0, raise}, 16'd0);
    rd(8'hB4, d);
    check("hs_status_clr", {8'h00, d}, 16'h0000);
    check("hs_stay_low", {15'd0, raise}, 16'd0);

    // Masked change on channel 0, then write-1-to-clear.
    wr(8'hB5, 8'h00);
    gpio_in[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | raise;
    end
    check("mask_raise", {15'd0, seen}, 16'd0);
    rd(8'hB4, d);
    check("mask_status", {8'h00, d}, 16'h0001);
    wr(8'hB4, 8'h01);
    rd(8'hB4, d);
    check("w1c_status", {8'h00, d}, 16'h0000);

    // Channel-1 change landing on the ACK edge.
    wr(8'hB5, 8'h02);
    gpio_in[8] = 1'b1;
    wait_raise("race_raise1");
    gpio_in[8] = 1'b0;
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("race_ack_drop", {15'd0, raise}, 16'd0);
    bus_addr = 8'hB4;
    tick();
    bus_addr = 8'h00;
    check("race_reraise", {15'd0, raise}, 16'd1);
    check("race_status", {8'h00, bus}, 16'h0002);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Channel-0 change landing on a W1C write edge.
    wr(8'hB5, 8'h00);
    gpio_in[0] = 1'b0;
    tick();
    tick();
    wr(8'hB4, 8'h01);
    rd(8'hB4, d);
    check("w1c_race", {8'h00, d}, 16'h0001);
    wr(8'hB4, 8'h03);
    rd(8'hB4, d);
    check("w1c_race_clr", {8'h00, d}, 16'h0000);

    // MASK cleared mid-handshake, then async reset while raised.
    wr(8'hB5, 8'h02);
    gpio_in[8] = 1'b1;
    wait_raise("mr_raise");
    wr(8'hB5, 8'h00);
    tick();
    check("mr_hold", {15'd0, raise}, 16'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_raise", {15'd0, raise}, 16'd0);
    check("arst_out", gpio_out, 16'h0000);
    check("arst_bus", {15'd0, bus_idle()}, 16'd1);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
